bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
// Two-requester round-robin arbiter and sequencer for one port of the byte-write-enable dual-port BRAM in the EtherIP frame buffer.
// Typical requesters: the MAC RX writer (req 0) and the descriptor/AXI readback engine (req 1).
// Issues at most one access per clock with burst fairness, and tracks read latency to route each returned word to its requester.
// PARAMETERS
// ADDR_W        16  BRAM word address width
// NB_COL        4   byte lanes per word
// COL_WIDTH     8   bits per byte lane; DATA_W = NB_COL*COL_WIDTH
// READ_LATENCY  2   BRAM read latency: 2 = registered output, 1 = unregistered; other values illegal
// MAX_BURST     8   max consecutive beats granted to one owner while the other requests; >=1
// PORTS
// clk_i     in   1                   single clock for arbiter and BRAM port
// rstn_i    in   1                   asynchronous, active-low reset
// req_i     in   2                   per-requester access request, held until granted
// we_i      in   2                   1 = write, 0 = read (per requester)
// be_i      in   2*NB_COL            byte enables, requester k at [k*NB_COL +: NB_COL]
// addr_i    in   2*ADDR_W            word address, requester k at [k*ADDR_W +: ADDR_W]
// wdata_i   in   2*DATA_W            write data, requester k at [k*DATA_W +: DATA_W]
// gnt_o     out  2                   combinational accept; a beat transfers when req_i[k] & gnt_o[k]
// rvalid_o  out  2                   read data valid for requester k, one cycle per read beat
// rdata_o   out  DATA_W              read data, shared by both requesters, qualified by rvalid_o
// bram_en_o    out  1                BRAM port enable
// bram_we_o    out  NB_COL           BRAM byte write enables
// bram_addr_o  out  ADDR_W           BRAM address
// bram_din_o   out  DATA_W           BRAM write data
// bram_regce_o out  1                BRAM output-register enable
// bram_rst_o   out  1                BRAM output reset; tied 0
// bram_dout_i  in   DATA_W           BRAM read data
// BEHAVIOUR
// - Reset (rstn_i low, async): state=IDLE, last_owner=1 (req 0 wins first), burst_cnt=0, read pipe cleared.
//   All outputs are 0 during reset and on the first cycle after it.
// - FSM states:
//   IDLE: no grants. Next state OWN0 or OWN1 when any req_i is high; if both, the one != last_owner wins.
//   OWNk: gnt_o[k] = req_i[k]; gnt_o[other] = 0.
// - OWNk transitions (registered):
//   - req_i[k]=0: no beat; go to OWN_other if req_i[other], else IDLE (one bubble cycle).
//   - beat accepted, burst_cnt==MAX_BURST-1, req_i[other]=1: go to OWN_other, burst_cnt=0, last_owner=k.
//   - beat accepted otherwise: stay; burst_cnt saturates at MAX_BURST-1.
//   - Burst-limit switches are bubble-free: back-to-back beats across owners.
// - The owner switch takes effect next cycle; gnt_o is never high for both requesters.
// - Issue (combinational, same cycle as gnt):
//   - bram_en_o = accepted beat.
//   - bram_we_o = we_i[k] ? be_i[k] : 0.
//   - bram_addr_o and bram_din_o come from the granted requester; 0 when idle.
// - Write with be=0 is a legal no-op beat: bram_en_o is asserted and no rvalid is produced.
// - Read pipe: READ_LATENCY-deep shift of {valid,id}, loaded on accepted read beats.
//   - rvalid_o[id] is asserted exactly READ_LATENCY cycles after acceptance; rdata_o = bram_dout_i.
//   - bram_regce_o = stage-0 valid (READ_LATENCY=2); constant 1 for READ_LATENCY=1.
// - Read data returns in issue order; reads may follow writes back-to-back.
// - Read-after-write to the same address on the next beat returns the new data.
// - Reset mid-operation: all in-flight reads are discarded and no rvalid follows.
// TESTING
// - Read return: req0 reads addr 0x0010 (holding 0xA5A5A5A5), accepted at cycle t -> bram_en_o=1 at t; rvalid_o=2'b01 at t+2 with rdata_o=0xA5A5A5A5.
// - Fairness: both requesters request continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... with no bubble cycles; gnt_o never 2'b11.
// - Byte enables: req1 writes 0x11223344 with be=4'b0101 to addr 5 (prior 0xFFFFFFFF), then reads addr 5 -> bram_we_o=0101; rvalid_o[1] shows 0xFF22FF44.
// - Owner drop: req0 owns, drops req while req1 requests -> exactly one idle cycle, then gnt_o=2'b10.
// - Reset: rstn_i low one cycle after two reads are accepted -> outputs 0 immediately; no rvalid_o afterwards; first grant after reset goes to req0.
// - READ_LATENCY=1 build: read accepted at t -> rvalid_o at t+1; bram_regce_o stays 1.

Source files
------------

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Two-requester round-robin arbiter/sequencer for one BRAM port
//               with burst fairness and read-return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter  int ADDR_W       = 16,
    parameter  int NB_COL       = 4,
    parameter  int COL_WIDTH    = 8,
    parameter  int READ_LATENCY = 2,
    parameter  int MAX_BURST    = 8,
    localparam int DATA_W       = NB_COL * COL_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*NB_COL-1:0]   be_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  bram_en_o,
    output logic [NB_COL-1:0]     bram_we_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    output logic [DATA_W-1:0]     bram_din_o,
    output logic                  bram_regce_o,
    output logic                  bram_rst_o,
    input  logic [DATA_W-1:0]     bram_dout_i
);

    localparam int c_CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last_owner;
    logic [c_CNT_W-1:0]   r_burst_cnt;

    logic                 w_own_valid;
    logic                 w_owner;
    logic                 w_req_own;
    logic                 w_req_oth;
    logic                 w_beat;
    logic                 w_rd_beat;
    logic                 w_burst_done;
    logic                 w_we_own;
    logic [NB_COL-1:0]    w_be_own;
    logic [ADDR_W-1:0]    w_addr_own;
    logic [DATA_W-1:0]    w_din_own;
    state_t               w_oth_state;
    logic                 w_ret_vld;
    logic                 w_ret_id;

    assign w_own_valid  = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_owner      = (r_state == ST_OWN1);
    assign w_req_own    = w_owner ? req_i[1] : req_i[0];
    assign w_req_oth    = w_owner ? req_i[0] : req_i[1];
    assign w_we_own     = w_owner ? we_i[1]  : we_i[0];
    assign w_be_own     = w_owner ? be_i[NB_COL +: NB_COL]    : be_i[0 +: NB_COL];
    assign w_addr_own   = w_owner ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
    assign w_din_own    = w_owner ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];
    assign w_oth_state  = w_owner ? ST_OWN0 : ST_OWN1;
    assign w_beat       = w_own_valid & w_req_own;
    assign w_rd_beat    = w_beat & ~w_we_own;
    assign w_burst_done = (r_burst_cnt == c_CNT_W'(MAX_BURST - 1));

    // Grant is a combinational accept from the current owner only.
    assign gnt_o        = w_beat ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
    assign bram_en_o    = w_beat;
    assign bram_we_o    = (w_beat & w_we_own) ? w_be_own : '0;
    assign bram_addr_o  = w_own_valid ? w_addr_own : '0;
    assign bram_din_o   = w_own_valid ? w_din_own  : '0;
    assign bram_rst_o   = 1'b0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_burst_cnt <= '0;
                    if (req_i[0] && req_i[1]) begin
                        r_state <= r_last_owner ? ST_OWN0 : ST_OWN1;
                    end else if (req_i[0]) begin
                        r_state <= ST_OWN0;
                    end else if (req_i[1]) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!w_req_own) begin
                        // Owner went quiet: hand over (or idle) with one bubble.
                        r_burst_cnt  <= '0;
                        r_last_owner <= w_owner;
                        r_state      <= w_req_oth ? w_oth_state : ST_IDLE;
                    end else if (w_burst_done && w_req_oth) begin
                        r_burst_cnt  <= '0;
                        r_last_owner <= w_owner;
                        r_state      <= w_oth_state;
                    end else if (!w_burst_done) begin
                        r_burst_cnt  <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    // Read-return pipe mirrors the BRAM latency so each word is routed to its issuer.
    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic [1:0] r_pipe_vld;
            logic [1:0] r_pipe_id;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_pipe_vld <= '0;
                    r_pipe_id  <= '0;
                end else begin
                    r_pipe_vld <= {r_pipe_vld[0], w_rd_beat};
                    r_pipe_id  <= {r_pipe_id[0], w_owner};
                end
            end

            assign w_ret_vld    = r_pipe_vld[1];
            assign w_ret_id     = r_pipe_id[1];
            assign bram_regce_o = r_pipe_vld[0];
        end else begin : g_rl1
            logic r_pipe_vld;
            logic r_pipe_id;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_pipe_vld <= 1'b0;
                    r_pipe_id  <= 1'b0;
                end else begin
                    r_pipe_vld <= w_rd_beat;
                    r_pipe_id  <= w_owner;
                end
            end

            assign w_ret_vld    = r_pipe_vld;
            assign w_ret_id     = r_pipe_id;
            assign bram_regce_o = 1'b1;
        end
    endgenerate

    assign rvalid_o = w_ret_vld ? (w_ret_id ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = w_ret_vld ? bram_dout_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Directed bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int RL = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (READ_LATENCY=2, MAX_BURST=4)
    logic        rstn;
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        en;
    logic [3:0]  bwe;
    logic [15:0] baddr;
    logic [31:0] bdin;
    logic        regce, brst;
    logic [31:0] bdout;

    bram_port_arbiter #(.ADDR_W(16), .NB_COL(4), .COL_WIDTH(8),
                        .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .bram_en_o(en), .bram_we_o(bwe), .bram_addr_o(baddr),
        .bram_din_o(bdin), .bram_regce_o(regce), .bram_rst_o(brst),
        .bram_dout_i(bdout));

    // Second DUT (READ_LATENCY=1)
    logic        b_rstn;
    logic [1:0]  b_req, b_we;
    logic [7:0]  b_be;
    logic [31:0] b_addr;
    logic [63:0] b_wdata;
    logic [1:0]  b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic        b_en;
    logic [3:0]  b_bwe;
    logic [15:0] b_baddr;
    logic [31:0] b_bdin;
    logic        b_regce, b_brst;
    logic [31:0] b_bdout = '0;

    bram_port_arbiter #(.ADDR_W(16), .NB_COL(4), .COL_WIDTH(8),
                        .READ_LATENCY(1), .MAX_BURST(8)) dut_b (
        .clk_i(clk), .rstn_i(b_rstn), .req_i(b_req), .we_i(b_we), .be_i(b_be),
        .addr_i(b_addr), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
        .rdata_o(b_rdata), .bram_en_o(b_en), .bram_we_o(b_bwe), .bram_addr_o(b_baddr),
        .bram_din_o(b_bdin), .bram_regce_o(b_regce), .bram_rst_o(b_brst),
        .bram_dout_i(b_bdout));

    // BRAM environment models
    logic [31:0] bmem [65536];
    logic [31:0] rmem [65536];
    logic [31:0] b_r1, b_r2;
    assign bdout = b_r2;

    always @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (bwe[i]) bmem[baddr][i*8 +: 8] <= bdin[i*8 +: 8];
            if (bwe == 4'b0000) b_r1 <= bmem[baddr];
        end
        if (regce) b_r2 <= b_r1;
    end

    always @(posedge clk) begin
        if (b_en) b_bdout <= (b_baddr == 16'h0020) ? 32'h1234_5678 : 32'h0;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner/last/run-length plus a queue of pending returns.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rd_t;

    rd_t pend[$];
    int  cyc    = 0;
    int  m_own  = -1;
    int  m_last = 1;
    int  m_run  = 0;

    always @(negedge clk) begin : p_model
        logic [1:0]  e_gnt, e_rv;
        logic        e_en, e_regce;
        logic [3:0]  e_we;
        logic [31:0] e_rd;
        logic [15:0] a;
        rd_t         r;
        int          k, o;
        cyc++;
        if (!rstn) begin
            m_own = -1; m_last = 1; m_run = 0;
            pend.delete();
            chk("m_rst_gnt", gnt, 0);
            chk("m_rst_rvalid", rvalid, 0);
            chk("m_rst_en", en, 0);
            chk("m_rst_we", bwe, 0);
            chk("m_rst_addr", baddr, 0);
            chk("m_rst_rdata", rdata, 0);
        end else begin
            e_gnt = 0; e_en = 0; e_we = 0; e_rv = 0; e_rd = 0; e_regce = 0;
            if (m_own >= 0 && req[m_own]) begin
                e_gnt[m_own] = 1'b1;
                e_en = 1'b1;
                e_we = we[m_own] ? be[m_own*4 +: 4] : 4'b0000;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_rv[pend[0].id] = 1'b1;
                e_rd = pend[0].data;
                void'(pend.pop_front());
            end
            foreach (pend[i]) if (pend[i].due == cyc + 1) e_regce = 1'b1;
            chk("m_gnt", gnt, e_gnt);
            chk("m_en", en, e_en);
            chk("m_we", bwe, e_we);
            chk("m_rvalid", rvalid, e_rv);
            chk("m_regce", regce, e_regce);
            chk("m_brst", brst, 0);
            if (e_rv != 0) chk("m_rdata", rdata, e_rd);
            if (e_en) begin
                chk("m_addr", baddr, addr[m_own*16 +: 16]);
                if (we[m_own]) chk("m_din", bdin, wdata[m_own*32 +: 32]);
            end
            // advance the model one cycle
            if (m_own < 0) begin
                if (req == 2'b11)  m_own = (m_last == 0) ? 1 : 0;
                else if (req[0])   m_own = 0;
                else if (req[1])   m_own = 1;
                m_run = 0;
            end else begin
                k = m_own; o = 1 - k;
                if (!req[k]) begin
                    m_last = k;
                    m_own  = req[o] ? o : -1;
                    m_run  = 0;
                end else begin
                    a = addr[k*16 +: 16];
                    if (we[k]) begin
                        for (int i = 0; i < 4; i++)
                            if (be[k*4 + i]) rmem[a][i*8 +: 8] = wdata[k*32 + i*8 +: 8];
                    end else begin
                        r.due = cyc + RL; r.id = k; r.data = rmem[a];
                        pend.push_back(r);
                    end
                    if (m_run >= MB - 1 && req[o]) begin
                        m_own = o; m_last = k; m_run = 0;
                    end else begin
                        m_run++;
                    end
                end
            end
        end
    end

    logic        last_en;
    logic [3:0]  last_we;
    logic [15:0] last_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for requester k, hold until granted, then release.
    task automatic issue(input int k, input bit w, input logic [3:0] b,
                         input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        req[k] = 1'b1; we[k] = w; be[k*4 +: 4] = b;
        addr[k*16 +: 16] = a; wdata[k*32 +: 32] = d;
        forever begin
            @(negedge clk);
            if (gnt[k]) break;
            n++;
            if (n > 16) begin
                chk("issue_timeout", gnt[k], 1);
                break;
            end
            tick();
        end
        last_en = en; last_we = bwe; last_addr = baddr;
        tick();
        req[k] = 1'b0; we[k] = 1'b0; be[k*4 +: 4] = '0;
        addr[k*16 +: 16] = '0; wdata[k*32 +: 32] = '0;
    endtask

    task automatic ret_chk(input int k, input logic [31:0] d, input string nm);
        @(negedge clk);
        chk({nm, "_early"}, rvalid, 0);
        tick();
        @(negedge clk);
        chk({nm, "_rvalid"}, rvalid, 2'b01 << k);
        chk({nm, "_rdata"}, rdata, d);
    endtask

    logic [1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                             2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 0; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        b_rstn = 0; b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 65536; i++) begin
            bmem[i] = '0; rmem[i] = '0;
        end
        bmem[16'h0010] = 32'hA5A5_A5A5; rmem[16'h0010] = 32'hA5A5_A5A5;
        bmem[16'h0005] = 32'hFFFF_FFFF; rmem[16'h0005] = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", {gnt, rvalid, en, bwe, baddr, bdin, rdata, regce}, 0);
        chk("b_regce_rst", b_regce, 1);
        tick();
        rstn = 1; b_rstn = 1;
        @(negedge clk);
        chk("post_rst_out", {gnt, rvalid, en, bwe, regce}, 0);
        tick();

        // Read return
        issue(0, 0, 4'h0, 16'h0010, 32'h0);
        chk("rd_en", last_en, 1);
        chk("rd_addr", last_addr, 16'h0010);
        ret_chk(0, 32'hA5A5_A5A5, "rd");
        tick();

        // Byte-enable write then read back
        issue(1, 1, 4'b0101, 16'h0005, 32'h1122_3344);
        chk("be_we", last_we, 4'b0101);
        issue(1, 0, 4'h0, 16'h0005, 32'h0);
        ret_chk(1, 32'hFF22_FF44, "be");
        repeat (2) tick();

        // Fairness with both requesting continuously
        req = 2'b11; we = 2'b11; be = 8'hFF;
        addr = {16'h0200, 16'h0100}; wdata = {32'h2222_2222, 32'h1111_1111};
        @(negedge clk);
        chk("fair_idle", gnt, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            chk("fair_gnt", gnt, pat[i]);
        end
        tick();
        req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        repeat (2) tick();

        // Owner drop; req0 issues no-op writes (be=0)
        req = 2'b11; we = 2'b01; be = 8'h00; addr = {16'h0010, 16'h0040};
        @(negedge clk);
        chk("drop_idle", gnt, 0);
        tick(); @(negedge clk);
        chk("drop_g0a", gnt, 2'b01);
        chk("noop_en", en, 1);
        chk("noop_we", bwe, 0);
        tick(); @(negedge clk);
        chk("drop_g0b", gnt, 2'b01);
        tick();
        req[0] = 0; we[0] = 0;
        @(negedge clk);
        chk("drop_bubble", {gnt, en}, 0);
        tick(); @(negedge clk);
        chk("drop_g1", gnt, 2'b10);
        tick();
        req = 0; addr = 0;
        repeat (4) tick();

        // Read-after-write on the next beat
        issue(0, 1, 4'hF, 16'h0030, 32'hDEAD_BEEF);
        issue(0, 0, 4'h0, 16'h0030, 32'h0);
        ret_chk(0, 32'hDEAD_BEEF, "raw");
        repeat (2) tick();

        // Reset with two reads in flight
        issue(1, 0, 4'h0, 16'h0010, 32'h0);
        issue(1, 0, 4'h0, 16'h0005, 32'h0);
        rstn = 0;
        #1;
        chk("midrst_out", {gnt, rvalid, en, bwe, baddr, bdin, rdata, regce}, 0);
        tick();
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", rvalid, 0);
            tick();
        end
        req = 2'b11; addr = {16'h0005, 16'h0010};
        @(negedge clk);
        chk("midrst_idle", gnt, 0);
        tick(); @(negedge clk);
        chk("midrst_first_gnt", gnt, 2'b01);
        tick();
        req = 0; addr = 0;
        repeat (4) tick();

        // READ_LATENCY=1 build
        b_req = 2'b01; b_addr = 32'h0000_0020;
        @(negedge clk);
        chk("b_idle", b_gnt, 0);
        tick(); @(negedge clk);
        chk("b_gnt", b_gnt, 2'b01);
        chk("b_en", b_en, 1);
        chk("b_regce_a", b_regce, 1);
        tick();
        b_req = 0; b_addr = 0;
        @(negedge clk);
        chk("b_rvalid", b_rvalid, 2'b01);
        chk("b_rdata", b_rdata, 32'h1234_5678);
        chk("b_regce_b", b_regce, 1);
        tick(); @(negedge clk);
        chk("b_rvalid_end", b_rvalid, 0);
        chk("b_brst", b_brst, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
